// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands in a small FIFO, presents each one
// to the combinational ALU from registers, captures the result and flags one
// cycle later and holds them on a valid/ready response channel.
module alu_cmd_sequencer #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_ch,
  input  logic [W-1:0] alu_f,
  input  logic         alu_zero,
  input  logic         alu_over,
  input  logic         alu_cout,
  input  logic         alu_less,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_f,
  output logic [3:0]   rsp_flags,
  output logic         busy,
  output logic [7:0]   op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [2:0]   op_mem [DEPTH];
  logic [W-1:0] a_mem  [DEPTH];
  logic [W-1:0] b_mem  [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic push;
  logic pop;
  logic capture;
  logic handshake;
  logic fifo_empty;

  // Full/empty come only from the registered count, so a pop in the same
  // cycle never frees a slot for a push into a full FIFO.
  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != FULL_COUNT);
  assign push       = cmd_valid && cmd_ready;
  assign busy       = !fifo_empty || (state != IDLE);

  // Command storage; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr] <= cmd_op;
      a_mem[wr_ptr]  <= cmd_a;
      b_mem[wr_ptr]  <= cmd_b;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: load from the FIFO head, let the ALU settle, then hold
  // the response until the consumer takes it.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    handshake  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        capture    = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (rsp_ready) begin
          handshake = 1'b1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ALU operand/select registers change only when a command is popped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_ch <= '0;
    end else if (pop) begin
      alu_a  <= a_mem[rd_ptr];
      alu_b  <= b_mem[rd_ptr];
      alu_ch <= op_mem[rd_ptr];
    end
  end

  // Response register: captured one cycle after load, held until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_f     <= '0;
      rsp_flags <= '0;
    end else if (capture) begin
      rsp_valid <= 1'b1;
      rsp_f     <= alu_f;
      rsp_flags <= {alu_less, alu_cout, alu_over, alu_zero};
    end else if (handshake) begin
      rsp_valid <= 1'b0;
    end
  end

  // Completed-response counter, sticking at its maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count <= '0;
    end else if (handshake && (op_count != 8'hFF)) begin
      op_count <= op_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: drives alu_cmd_sequencer against a behavioural 4-bit
// ALU and compares every cycle with a queue-based transaction model.
module tb_alu_cmd_sequencer;

  localparam int W     = 4;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef struct packed {
    logic [3:0] f;
    logic [3:0] flags;
  } rsp_t;

  typedef struct {
    cmd_t       cmd;
    logic [3:0] f;
    logic [3:0] flags;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = '0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_ch;
  logic [W-1:0] alu_f;
  logic         alu_zero;
  logic         alu_over;
  logic         alu_cout;
  logic         alu_less;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_f;
  logic [3:0]   rsp_flags;
  logic         busy;
  logic [7:0]   op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  // Transaction model: commands waiting, plus the one in the ALU/response path.
  cmd_t m_fifo[$];
  int   m_stage = 0;
  cmd_t m_cur   = '0;
  rsp_t m_rsp   = '0;
  int   m_count = 0;

  vec_t vecs[10];

  alu_cmd_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ch    (alu_ch),
    .alu_f     (alu_f),
    .alu_zero  (alu_zero),
    .alu_over  (alu_over),
    .alu_cout  (alu_cout),
    .alu_less  (alu_less),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_f     (rsp_f),
    .rsp_flags (rsp_flags),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  // Reference 4-bit ALU: result plus {less, cout, over, zero}.
  function automatic rsp_t alu_eval(input cmd_t c);
    rsp_t       r;
    logic [4:0] s;
    logic [3:0] f;
    logic       cout;
    logic       over;
    logic       less;
    s    = '0;
    f    = '0;
    cout = 1'b0;
    over = 1'b0;
    less = ($signed(c.a) < $signed(c.b));
    case (c.op)
      3'd0: begin
        s    = {1'b0, c.a} + {1'b0, c.b};
        f    = s[3:0];
        cout = s[4];
        over = (c.a[3] == c.b[3]) && (f[3] != c.a[3]);
      end
      3'd1: begin
        s    = {1'b0, c.a} + {1'b0, ~c.b} + 5'd1;
        f    = s[3:0];
        cout = s[4];
        over = (c.a[3] != c.b[3]) && (f[3] != c.a[3]);
      end
      3'd2:    f = ~c.a;
      3'd3:    f = c.a & c.b;
      3'd4:    f = c.a | c.b;
      3'd5:    f = c.a ^ c.b;
      3'd6:    f = {3'b000, less};
      default: f = {3'b000, (c.a == c.b)};
    endcase
    r.f     = f;
    r.flags = {less, cout, over, (f == 4'd0)};
    return r;
  endfunction

  cmd_t env_cmd;
  rsp_t env_rsp;
  assign env_cmd  = {alu_ch, alu_a, alu_b};
  assign env_rsp  = alu_eval(env_cmd);
  assign alu_f    = env_rsp.f;
  assign alu_less = env_rsp.flags[3];
  assign alu_cout = env_rsp.flags[2];
  assign alu_over = env_rsp.flags[1];
  assign alu_zero = env_rsp.flags[0];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit valid, input logic [2:0] op, input logic [3:0] a,
                               input logic [3:0] b, input bit ready);
    cmd_valid = valid;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    rsp_ready = ready;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op = 3'($urandom_range(0, 7));
    c.a  = 4'($urandom_range(0, 15));
    c.b  = 4'($urandom_range(0, 15));
    return c;
  endfunction

  // One model step per clock edge (or immediately on reset): queued commands
  // are not visible to the engine until the edge after they were accepted.
  task automatic model_step();
    bit   do_push;
    cmd_t nc;
    if (rst) begin
      m_fifo.delete();
      m_stage = 0;
      m_cur   = '0;
      m_rsp   = '0;
      m_count = 0;
    end else begin
      do_push = cmd_valid && (m_fifo.size() < DEPTH);
      nc      = {cmd_op, cmd_a, cmd_b};
      case (m_stage)
        0: begin
          if (m_fifo.size() > 0) begin
            m_cur   = m_fifo.pop_front();
            m_stage = 1;
          end
        end
        1: begin
          m_rsp   = alu_eval(m_cur);
          m_stage = 2;
        end
        default: begin
          if (rsp_ready) begin
            if (m_count < 255) m_count++;
            if (m_fifo.size() > 0) begin
              m_cur   = m_fifo.pop_front();
              m_stage = 1;
            end else begin
              m_stage = 0;
            end
          end
        end
      endcase
      if (do_push) m_fifo.push_back(nc);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Cycle-by-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && !rst) begin
        checkOutput("m_cmd_ready", 32'(cmd_ready), 32'(m_fifo.size() < DEPTH));
        checkOutput("m_rsp_valid", 32'(rsp_valid), 32'(m_stage == 2));
        if (m_stage == 2) checkOutput("m_rsp_data", 32'({rsp_f, rsp_flags}), 32'(m_rsp));
        checkOutput("m_busy", 32'(busy), 32'((m_fifo.size() != 0) || (m_stage != 0)));
        checkOutput("m_op_count", 32'(op_count), 32'(m_count));
        checkOutput("m_alu_regs", 32'({alu_ch, alu_a, alu_b}), 32'(m_cur));
      end
    end
  end

  initial begin
    #400000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    cmd_t offers[7];
    rsp_t held;
    int   accepted;
    int   got;
    int   hs_cyc[3];
    int   hs;
    int   t;

    vecs[0] = '{{3'b000, 4'b0111, 4'b0001}, 4'b1000, 4'b0010};
    vecs[1] = '{{3'b001, 4'b0000, 4'b0000}, 4'b0000, 4'b0101};
    vecs[2] = '{{3'b001, 4'b0011, 4'b0101}, 4'b1110, 4'b1000};
    vecs[3] = '{{3'b011, 4'b1100, 4'b1010}, 4'b1000, 4'b0000};
    vecs[4] = '{{3'b101, 4'b1111, 4'b1111}, 4'b0000, 4'b0001};
    vecs[5] = '{{3'b110, 4'b1000, 4'b0001}, 4'b0001, 4'b1000};
    vecs[6] = '{{3'b111, 4'b0101, 4'b0101}, 4'b0001, 4'b0000};
    vecs[7] = '{{3'b010, 4'b0000, 4'b0011}, 4'b1111, 4'b1000};
    vecs[8] = '{{3'b000, 4'b1000, 4'b1000}, 4'b0000, 4'b0111};
    vecs[9] = '{{3'b100, 4'b0000, 4'b0000}, 4'b0000, 4'b0001};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_op_count", 32'(op_count), 32'd0);
    checkOutput("reset_alu_regs", 32'({alu_ch, alu_a, alu_b}), 32'd0);
    checkOutput("reset_rsp_data", 32'({rsp_f, rsp_flags}), 32'd0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Table-driven single commands: latency, loaded operands, result, count
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("tbl_cmd_ready", 32'(cmd_ready), 32'd1);
      applyStimulus(1'b1, vecs[i].cmd.op, vecs[i].cmd.a, vecs[i].cmd.b, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
      checkOutput("tbl_lat_accept", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      checkOutput("tbl_lat_load", 32'(rsp_valid), 32'd0);
      checkOutput("tbl_load", 32'({alu_ch, alu_a, alu_b}), 32'(vecs[i].cmd));
      @(negedge clk);
      checkOutput("tbl_valid", 32'(rsp_valid), 32'd1);
      checkOutput("tbl_rsp", 32'({rsp_f, rsp_flags}), 32'({vecs[i].f, vecs[i].flags}));
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput("tbl_done", 32'(rsp_valid), 32'd0);
      checkOutput("tbl_count", 32'(op_count), 32'(i + 1));
    end

    // Backpressure: seven offers with the consumer stalled
    accepted = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      offers[k] = rand_cmd();
      applyStimulus(1'b1, offers[k].op, offers[k].a, offers[k].b, 1'b0);
      if (cmd_ready) accepted++;
    end
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
    checkOutput("bp_accepted", 32'(accepted), 32'd5);
    checkOutput("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
    held = alu_eval(offers[0]);
    repeat (3) @(negedge clk);
    checkOutput("bp_stable", 32'({rsp_f, rsp_flags}), 32'(held));
    checkOutput("bp_cmd_ready_hold", 32'(cmd_ready), 32'd0);
    rsp_ready = 1'b1;
    got = 0;
    t   = 0;
    while (got < 5 && t < 40) begin
      if (rsp_valid) begin
        checkOutput("bp_order", 32'({rsp_f, rsp_flags}), 32'(alu_eval(offers[got])));
        got++;
      end
      @(negedge clk);
      t++;
    end
    checkOutput("bp_got", 32'(got), 32'd5);
    rsp_ready = 1'b0;

    // Throughput with the consumer always ready
    @(negedge clk);
    checkOutput("tp_idle", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      offers[k] = rand_cmd();
      applyStimulus(1'b1, offers[k].op, offers[k].a, offers[k].b, 1'b1);
      @(negedge clk);
    end
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
    got = 0;
    t   = 0;
    while (got < 3 && t < 30) begin
      if (rsp_valid) begin
        hs_cyc[got] = cyc;
        checkOutput("tp_data", 32'({rsp_f, rsp_flags}), 32'(alu_eval(offers[got])));
        if (got == 2) checkOutput("tp_busy_last", 32'(busy), 32'd1);
        got++;
      end
      @(negedge clk);
      t++;
    end
    checkOutput("tp_got", 32'(got), 32'd3);
    checkOutput("tp_gap1", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
    checkOutput("tp_gap2", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
    checkOutput("tp_busy_drop", 32'(busy), 32'd0);
    rsp_ready = 1'b0;

    // Asynchronous reset while a response waits and two commands are queued
    for (int k = 0; k < 3; k++) begin
      offers[k] = rand_cmd();
      applyStimulus(1'b1, offers[k].op, offers[k].a, offers[k].b, 1'b0);
      @(negedge clk);
    end
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b0);
    checkOutput("ar_pre_valid", 32'(rsp_valid), 32'd1);
    checkOutput("ar_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", 32'(rsp_valid), 32'd0);
    checkOutput("ar_busy", 32'(busy), 32'd0);
    checkOutput("ar_op_count", 32'(op_count), 32'd0);
    checkOutput("ar_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("ar_no_stale", 32'({rsp_valid, busy}), 32'd0);
    end

    // Randomised traffic, checked cycle by cycle against the model
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      offers[0] = rand_cmd();
      applyStimulus($urandom_range(0, 99) < 60, offers[0].op, offers[0].a, offers[0].b,
                    $urandom_range(0, 99) < 50);
    end
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("rnd_drain", 32'(busy), 32'd0);

    // Saturation of the completed-response counter
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hs = 0;
    t  = 0;
    while (hs < 260 && t < 1500) begin
      @(negedge clk);
      offers[0] = rand_cmd();
      applyStimulus(1'b1, offers[0].op, offers[0].a, offers[0].b, 1'b1);
      if (rsp_valid) hs++;
      t++;
    end
    checkOutput("sat_handshakes", 32'(hs), 32'd260);
    applyStimulus(1'b0, 3'd0, 4'd0, 4'd0, 1'b1);
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    checkOutput("sat_drain", 32'(busy), 32'd0);
    checkOutput("sat_op_count", 32'(op_count), 32'd255);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the lab ALU: buffers operation commands, drives the combinational ALU operand/select inputs from registers, captures result and flags one cycle later, and returns them on a valid/ready response channel.
- Sits between the switch/keyboard input logic and the 4-bit ALU so that commands can be queued and results consumed at the display's pace.

Parameters:
- W, 4, operand and result width.
- DEPTH, 4, command FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command FIFO can accept
- cmd_op  in  3  ALU select code
- cmd_a  in  W  operand a
- cmd_b  in  W  operand b
- alu_a  out  W  registered operand a to ALU
- alu_b  out  W  registered operand b to ALU
- alu_ch  out  3  registered ALU select
- alu_f  in  W  ALU result
- alu_zero  in  1  ALU zero flag
- alu_over  in  1  ALU signed-overflow flag
- alu_cout  in  1  ALU carry-out
- alu_less  in  1  ALU less-than result
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_f  out  W  captured result
- rsp_flags  out  4  captured {less, cout, over, zero}
- busy  out  1  FIFO non-empty or FSM not IDLE
- op_count  out  8  completed responses, saturating at 255

Behaviour:
- Reset, asynchronous and immediate: FIFO empty, all pointers 0, FSM=IDLE, alu_a/alu_b/alu_ch=0, rsp_valid=0, rsp_f=0, rsp_flags=0, op_count=0.
  - cmd_ready=1 after reset.
  - Reset mid-operation discards queued commands and any pending response.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = !full, purely from registered count. No push when full even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
  - Pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE: if FIFO non-empty, load alu_a/alu_b/alu_ch from the head, pop, go to ISSUE. A command pushed into an empty FIFO is not visible to IDLE until the next edge (no bypass).
  - ISSUE: ALU settles combinationally. On the next edge, capture rsp_f=alu_f and rsp_flags={alu_less,alu_cout,alu_over,alu_zero}, set rsp_valid=1, go to WAIT.
  - WAIT: rsp_valid and rsp_* stay stable until rsp_ready=1. On handshake:
    - rsp_valid clears and op_count increments (saturating).
    - If the FIFO is non-empty, load the next head into the ALU registers, pop, go to ISSUE; otherwise go to IDLE.
  - alu_a/alu_b/alu_ch hold their last values outside loads.
- Latency and throughput:
  - Command accepted at edge N into an empty FIFO in IDLE → ALU registers loaded at edge N+1 → rsp_valid=1 after edge N+2.
  - Sustained throughput with rsp_ready tied high is one response per 2 cycles.
- Flags are passed through unmodified. No arithmetic is done in this block. Op encoding is owned by the ALU:
  - 000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 signed less, 111 equal.
- busy = (count!=0) || (state!=IDLE).

Test Plan:
- Reset, then cmd op=000 a=0111 b=0001 → rsp_valid 2 cycles after accept; rsp_f=1000, rsp_flags=0010 (over=1, cout=0, zero=0); op_count=1 after handshake.
- op=001 a=0000 b=0000 → rsp_f=0000, zero=1, cout=1, over=0; op=001 a=0011 b=0101 → rsp_f=1110, cout=0.
- rsp_ready held 0, offer 7 back-to-back commands → exactly 5 accepted (1 in response register, 4 in FIFO); cmd_ready=0 from then on; rsp_f stable; release rsp_ready → 5 responses in command order.
- rsp_ready tied 1, 3 queued commands → responses spaced exactly 2 cycles apart; busy drops the cycle after the last handshake.
- Assert rst during WAIT with 2 queued commands → rsp_valid=0, busy=0, op_count=0, cmd_ready=1 immediately (asynchronous, before the next edge); no stale response after release.
- 260 handshakes → op_count saturates at 255.
